// File: rtl/ctrlsig_bubble_reg.sv
// ctrlsig_bubble_reg: registered ID/EX control-bundle stage with multi-cycle
// bubble insertion, stall (hold), flush, and a saturating bubble counter.
module ctrlsig_bubble_reg #(
   parameter int                 CTRL_W  = 18,
   parameter logic [CTRL_W-1:0]  NOP_VAL = {CTRL_W{1'b0}},
   parameter int                 BUB_W   = 2,
   parameter int                 STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic              stall,
   input  logic              flush,
   input  logic              bubble_req,
   input  logic [BUB_W-1:0]  bubble_len,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic              bubble_active,
   output logic              upstream_hold,
   output logic [STAT_W-1:0] bubble_total
);

   typedef enum logic {
      IDLE   = 1'b0,
      BUBBLE = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [BUB_W-1:0]  rem_reg, rem_next;
   logic [CTRL_W-1:0] ctrl_out_reg, ctrl_out_next;
   logic              bubble_active_reg, bubble_active_next;
   logic [STAT_W-1:0] bubble_total_reg, bubble_total_next;
   logic [STAT_W-1:0] total_inc;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   always_comb begin
      total_inc = bubble_total_reg;
      if (bubble_total_reg != {STAT_W{1'b1}})
         total_inc = bubble_total_reg + STAT_W'(1);
   end

   // Next-state logic; priority is flush, then stall, then bubble/pass handling.
   always_comb begin
      state_next         = state_reg;
      rem_next           = rem_reg;
      ctrl_out_next      = ctrl_out_reg;
      bubble_active_next = bubble_active_reg;
      bubble_total_next  = bubble_total_reg;

      if (flush) begin
         // Cancel pending bubbles; a flushed NOP is not counted as a bubble.
         ctrl_out_next      = NOP_VAL;
         bubble_active_next = 1'b0;
         rem_next           = '0;
         state_next         = IDLE;
      end else if (!stall) begin
         case (state_reg)
            IDLE: begin
               if (bubble_req) begin
                  ctrl_out_next      = NOP_VAL;
                  bubble_active_next = 1'b1;
                  bubble_total_next  = total_inc;
                  rem_next           = bubble_len;
                  // A length field of zero means a single bubble: no BUBBLE state.
                  state_next         = (bubble_len != '0) ? BUBBLE : IDLE;
               end else begin
                  ctrl_out_next      = ctrl_in;
                  bubble_active_next = 1'b0;
               end
            end
            BUBBLE: begin
               ctrl_out_next      = NOP_VAL;
               bubble_active_next = 1'b1;
               bubble_total_next  = total_inc;
               rem_next           = rem_reg - BUB_W'(1);
               if (rem_reg == BUB_W'(1))
                  state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
               rem_next   = '0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         rem_reg           <= '0;
         ctrl_out_reg      <= NOP_VAL;
         bubble_active_reg <= 1'b0;
         bubble_total_reg  <= '0;
      end else begin
         state_reg         <= state_next;
         rem_reg           <= rem_next;
         ctrl_out_reg      <= ctrl_out_next;
         bubble_active_reg <= bubble_active_next;
         bubble_total_reg  <= bubble_total_next;
      end
   end

   assign ctrl_out      = ctrl_out_reg;
   assign bubble_active = bubble_active_reg;
   assign upstream_hold = (state_reg == BUBBLE);
   assign bubble_total  = bubble_total_reg;

endmodule

// File: tb/tb_ctrlsig_bubble_reg.sv
// tb_ctrlsig_bubble_reg: directed test of the bubble register stage; a second
// instance with a 4-bit statistics counter exercises saturation.
module tb_ctrlsig_bubble_reg;

   localparam int CTRL_W = 18;
   localparam int BUB_W  = 2;

   logic              clk;
   logic              rst_n;
   logic [CTRL_W-1:0] ctrl_in;
   logic              stall;
   logic              flush;
   logic              bubble_req;
   logic [BUB_W-1:0]  bubble_len;

   logic [CTRL_W-1:0] ctrl_out;
   logic              bubble_active;
   logic              upstream_hold;
   logic [15:0]       bubble_total;

   logic [CTRL_W-1:0] ctrl_out_s;
   logic              bubble_active_s;
   logic              upstream_hold_s;
   logic [3:0]        bubble_total_s;

   int n_cmp;
   int n_err;

   ctrlsig_bubble_reg #(.CTRL_W(CTRL_W), .BUB_W(BUB_W), .STAT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .stall(stall), .flush(flush),
      .bubble_req(bubble_req), .bubble_len(bubble_len), .ctrl_out(ctrl_out),
      .bubble_active(bubble_active), .upstream_hold(upstream_hold),
      .bubble_total(bubble_total)
   );

   ctrlsig_bubble_reg #(.CTRL_W(CTRL_W), .BUB_W(BUB_W), .STAT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .stall(stall), .flush(flush),
      .bubble_req(bubble_req), .bubble_len(bubble_len), .ctrl_out(ctrl_out_s),
      .bubble_active(bubble_active_s), .upstream_hold(upstream_hold_s),
      .bubble_total(bubble_total_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports mismatches.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
      $display("t=%0t in=%05h req=%0b len=%0d stall=%0b flush=%0b -> out=%05h act=%0b hold=%0b total=%0d",
               $time, ctrl_in, bubble_req, bubble_len, stall, flush,
               ctrl_out, bubble_active, upstream_hold, bubble_total);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      chk("rst_ctrl_out", 32'(ctrl_out), 32'h0);
      chk("rst_active",   32'(bubble_active), 32'h0);
      chk("rst_hold",     32'(upstream_hold), 32'h0);
      chk("rst_total",    32'(bubble_total), 32'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      ctrl_in    = 18'h2A5C1;
      stall      = 1'b0;
      flush      = 1'b0;
      bubble_req = 1'b0;
      bubble_len = '0;

      // Reset and pass-through
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pass_out", 32'(ctrl_out), 32'h2A5C1);
         chk("pass_act", 32'(bubble_active), 32'h0);
      end
      ctrl_in = 18'h15A3E;
      step();
      chk("pass_out2", 32'(ctrl_out), 32'h15A3E);

      // Single bubble (len 0)
      bubble_req = 1'b1; bubble_len = 2'd0;
      step();
      chk("b1_out",   32'(ctrl_out), 32'h0);
      chk("b1_act",   32'(bubble_active), 32'h1);
      chk("b1_hold",  32'(upstream_hold), 32'h0);
      chk("b1_total", 32'(bubble_total), 32'h1);
      bubble_req = 1'b0; ctrl_in = 18'h0F0F0;
      step();
      chk("b1_resume", 32'(ctrl_out), 32'h0F0F0);
      chk("b1_act2",   32'(bubble_active), 32'h0);
      chk("b1_total2", 32'(bubble_total), 32'h1);

      // Stall in IDLE ignores bubble_req and holds the output
      stall = 1'b1; bubble_req = 1'b1; ctrl_in = 18'h00001;
      step();
      chk("stidle_out",   32'(ctrl_out), 32'h0F0F0);
      chk("stidle_total", 32'(bubble_total), 32'h1);
      chk("stidle_hold",  32'(upstream_hold), 32'h0);
      stall = 1'b0; bubble_req = 1'b0;

      // Max bubble (len 3) with a stall on the 2nd bubble cycle
      do_reset();
      ctrl_in = 18'h3FFFF; bubble_req = 1'b1; bubble_len = 2'd3;
      step();
      chk("mx0_out", 32'(ctrl_out), 32'h0);
      chk("mx0_hold", 32'(upstream_hold), 32'h1);
      chk("mx0_total", 32'(bubble_total), 32'h1);
      bubble_req = 1'b0;
      step();
      chk("mx1_out", 32'(ctrl_out), 32'h0);
      chk("mx1_hold", 32'(upstream_hold), 32'h1);
      chk("mx1_total", 32'(bubble_total), 32'h2);
      stall = 1'b1;
      step();
      chk("mx2_out", 32'(ctrl_out), 32'h0);
      chk("mx2_act", 32'(bubble_active), 32'h1);
      chk("mx2_hold", 32'(upstream_hold), 32'h1);
      chk("mx2_total", 32'(bubble_total), 32'h2);
      stall = 1'b0;
      step();
      chk("mx3_hold", 32'(upstream_hold), 32'h1);
      chk("mx3_total", 32'(bubble_total), 32'h3);
      step();
      chk("mx4_out", 32'(ctrl_out), 32'h0);
      chk("mx4_act", 32'(bubble_active), 32'h1);
      chk("mx4_hold", 32'(upstream_hold), 32'h0);
      chk("mx4_total", 32'(bubble_total), 32'h4);
      step();
      chk("mx5_out", 32'(ctrl_out), 32'h3FFFF);
      chk("mx5_act", 32'(bubble_active), 32'h0);
      chk("mx5_total", 32'(bubble_total), 32'h4);

      // Flush mid-bubble (len 2)
      do_reset();
      ctrl_in = 18'h12345; bubble_req = 1'b1; bubble_len = 2'd2;
      step();
      chk("fl0_hold", 32'(upstream_hold), 32'h1);
      bubble_req = 1'b0; flush = 1'b1;
      step();
      chk("fl1_out",   32'(ctrl_out), 32'h0);
      chk("fl1_act",   32'(bubble_active), 32'h0);
      chk("fl1_hold",  32'(upstream_hold), 32'h0);
      chk("fl1_total", 32'(bubble_total), 32'h1);
      flush = 1'b0;
      step();
      chk("fl2_out",   32'(ctrl_out), 32'h12345);
      chk("fl2_total", 32'(bubble_total), 32'h1);

      // Flush together with bubble_req (and stall): one uncounted NOP
      flush = 1'b1; bubble_req = 1'b1; stall = 1'b1; bubble_len = 2'd3;
      step();
      chk("flr_out",   32'(ctrl_out), 32'h0);
      chk("flr_act",   32'(bubble_active), 32'h0);
      chk("flr_hold",  32'(upstream_hold), 32'h0);
      chk("flr_total", 32'(bubble_total), 32'h1);
      flush = 1'b0; bubble_req = 1'b0; stall = 1'b0;
      step();
      chk("flr_resume", 32'(ctrl_out), 32'h12345);

      // Asynchronous reset mid-bubble
      bubble_req = 1'b1; bubble_len = 2'd3;
      step();
      bubble_req = 1'b0;
      chk("ar_pre_hold", 32'(upstream_hold), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_out",   32'(ctrl_out), 32'h0);
      chk("ar_act",   32'(bubble_active), 32'h0);
      chk("ar_hold",  32'(upstream_hold), 32'h0);
      chk("ar_total", 32'(bubble_total), 32'h0);
      step();
      rst_n = 1'b1;
      ctrl_in = 18'h0ABCD;
      step();
      chk("ar_resume", 32'(ctrl_out), 32'h0ABCD);
      chk("ar_hold2",  32'(upstream_hold), 32'h0);

      // Saturation: five 4-cycle bubbles = 20 bubble cycles
      do_reset();
      for (int r = 0; r < 5; r++) begin
         bubble_req = 1'b1; bubble_len = 2'd3;
         step();
         bubble_req = 1'b0;
         step();
         step();
         step();
         if (r == 2) chk("sat_mid", 32'(bubble_total_s), 32'd12);
      end
      chk("sat_small", 32'(bubble_total_s), 32'd15);
      chk("sat_wide",  32'(bubble_total), 32'd20);
      step();
      chk("sat_hold", 32'(bubble_total_s), 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ctrlsig_bubble_reg.md
# ctrlsig_bubble_reg

Parametrised, registered successor to the ID/EX control-signal NOP mux. Sits between the control unit and the EX stage, captures the packed control bundle each cycle, and replaces it with a NOP pattern when the hazard detection unit requests a bubble. A bubble request may last from 1 to 2^BUB_W cycles. The block also supports stall (hold) and flush, and keeps a saturating count of inserted bubbles for performance debug.

## Interface
Parameters:
- CTRL_W, 18, width of the packed control bundle {alualtsrc, alusrc[1:0], regdst[1:0], aluop[2:0], memwr, memrd, bbne, bbeq, bblez, bbgtz, jump, memtoreg[1:0], regwr}, MSB first.
- NOP_VAL, {CTRL_W{1'b0}}, bundle value driven for a bubble, a flush or a reset.
- BUB_W, 2, width of the bubble-length field.
- STAT_W, 16, width of the bubble statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ctrl_in  in  CTRL_W  control bundle from the control unit.
- stall  in  1  hold all state and ctrl_out this cycle.
- flush  in  1  force NOP into ctrl_out and cancel any pending bubbles.
- bubble_req  in  1  request bubble insertion; sampled only in IDLE.
- bubble_len  in  BUB_W  number of bubbles minus 1 (0 gives 1 bubble; all-ones gives 2^BUB_W bubbles).
- ctrl_out  out  CTRL_W  registered control bundle to the EX stage.
- bubble_active  out  1  registered; high while ctrl_out holds a bubble-generated NOP.
- upstream_hold  out  1  combinational; high in BUBBLE state, tells the hazard unit to keep PC and IF/ID frozen.
- bubble_total  out  STAT_W  saturating count of bubble cycles inserted.

## Operation
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- States: IDLE and BUBBLE. A remaining-bubble counter rem is BUB_W bits wide.
- Priority each cycle: flush > stall > bubble handling > normal pass.
- flush (any state):
  - ctrl_out <= NOP_VAL, bubble_active <= 0.
  - rem <= 0, state <= IDLE.
  - bubble_total is unchanged.
  - flush overrides stall.
- stall without flush: ctrl_out, bubble_active, rem, state and bubble_total all hold. bubble_req is ignored; the hazard unit must re-assert it.
- IDLE, no stall or flush:
  - With bubble_req: ctrl_out <= NOP_VAL, bubble_active <= 1, bubble_total increments. rem <= bubble_len. state <= BUBBLE if bubble_len != 0, else state stays IDLE.
  - Without bubble_req: ctrl_out <= ctrl_in, bubble_active <= 0.
- BUBBLE, no stall or flush:
  - ctrl_out <= NOP_VAL, bubble_active <= 1, bubble_total increments.
  - rem <= rem - 1; state <= IDLE when rem == 1.
  - bubble_req and ctrl_in are ignored.
- bubble_total saturates at 2^STAT_W - 1 and never wraps.
- upstream_hold = (state == BUBBLE). In the request cycle itself, the hazard unit is responsible for freezing IF/ID.

## Timing
- Reset values: ctrl_out = NOP_VAL, bubble_active = 0, upstream_hold = 0, bubble_total = 0, state = IDLE, rem = 0.
- Reset is asynchronous: outputs take their reset values immediately on rst_n falling, with no clock needed. Asserting reset mid-bubble discards the pending bubbles.
- Latency from ctrl_in to ctrl_out is 1 cycle.
- A request with bubble_len = L produces exactly L+1 consecutive non-stalled NOP cycles on ctrl_out, starting the edge after the request. ctrl_in is passed again on the next non-stalled edge after that.
- Stall cycles stretch a bubble sequence but never shorten it or add bubbles.
- A flush in the same cycle as bubble_req gives one NOP cycle, with bubble_active = 0 and no count increment.
- rem never underflows: BUBBLE is only entered with rem ≥ 1.
- upstream_hold falls in the same cycle the state returns to IDLE.

## Test plan
- Reset and pass-through: hold rst_n low for 2 cycles, then drive ctrl_in = 18'h2A5C1 for 3 cycles. Required: ctrl_out = 0 during reset, then 18'h2A5C1 one cycle after each input; bubble_active = 0 throughout.
- Single bubble: bubble_req = 1 with bubble_len = 0 for one cycle. Required: exactly 1 NOP cycle with bubble_active = 1, upstream_hold stays 0, bubble_total = 1, then pass-through resumes.
- Max bubble with stall: bubble_len = 3, then stall = 1 on the 2nd bubble cycle. Required: 4 NOP cycles spread over 5 clocks, upstream_hold high for 4 clocks, bubble_total = 4.
- Flush mid-bubble: bubble_len = 2, then flush on the 2nd bubble cycle. Required: state returns to IDLE, ctrl_out = NOP with bubble_active = 0, next cycle passes ctrl_in, bubble_total = 1.
- Async reset mid-bubble: drop rst_n between edges during BUBBLE. Required: all outputs take reset values immediately, with no clock needed.
- Saturation: with STAT_W = 4, insert 20 bubble cycles. Required: bubble_total stops at 15.
